// File: rtl/sram_march_pattern_tester_if.sv
// Handshake bundle between the march pattern tester (master) and the
// byte-wide SRAM controller (slave).
interface sram_march_pattern_tester_if #(
  parameter int ADDR_WIDTH = 19
);
  logic                  start_output;
  logic                  read_or_write_output;
  logic [ADDR_WIDTH-1:0] address_output;
  logic [7:0]            data_output;
  logic [7:0]            data_from_controller_input;
  logic                  data_ready_signal_input;
  logic                  writing_finished_signal_input;
  logic                  busy_signal_input;

  modport master (
    output start_output, read_or_write_output, address_output, data_output,
    input  data_from_controller_input, data_ready_signal_input,
           writing_finished_signal_input, busy_signal_input
  );

  modport slave (
    input  start_output, read_or_write_output, address_output, data_output,
    output data_from_controller_input, data_ready_signal_input,
           writing_finished_signal_input, busy_signal_input
  );
endinterface

// File: rtl/sram_march_pattern_tester.sv
// Four-pass march tester (write P, read P, write ~P, read ~P) over the SRAM controller.
// Optional first-error capture is built when SRAM_TESTER_ERROR_LOG_EN is defined.
module sram_march_pattern_tester #(
  parameter int                    ADDR_WIDTH        = 19,
  parameter logic [ADDR_WIDTH-1:0] LAST_ADDRESS      = ADDR_WIDTH'(19'h7FFFF),
  parameter int                    ERROR_COUNT_WIDTH = 16,
  parameter int                    TIMEOUT_CYCLES    = 16
) (
  input  logic                         clock_50_mhz_input,
  input  logic                         reset_n_input,
  input  logic                         start_test_input,
  sram_march_pattern_tester_if.master  ctrl,
  output logic                         test_running_output,
  output logic                         test_done_output,
  output logic                         test_pass_output,
  output logic                         timeout_error_output,
  output logic [1:0]                   pass_index_output,
  output logic [ERROR_COUNT_WIDTH-1:0] error_count_output,
  output logic [ADDR_WIDTH-1:0]        first_error_address_output,
  output logic [7:0]                   first_error_expected_output,
  output logic [7:0]                   first_error_actual_output
);

  localparam int EXT_W = (ADDR_WIDTH > 19) ? ADDR_WIDTH : 19;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, WAIT_IDLE, NEXT, DONE} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WD_W-1:0]       watchdog;
  logic [7:0]            expected_byte;
  logic                  mismatch;

  // Address bits beyond ADDR_WIDTH are treated as zero.
  function automatic logic [7:0] pattern(input logic [ADDR_WIDTH-1:0] a);
    logic [EXT_W-1:0] w;
    w = EXT_W'(a);
    return w[7:0] ^ w[15:8] ^ {5'b0, w[18:16]};
  endfunction

  // Passes 2/3 use the inverted pattern; this byte is both write data and compare value.
  assign expected_byte = pass_index_output[1] ? ~pattern(addr) : pattern(addr);
  assign mismatch      = (ctrl.data_from_controller_input != expected_byte);

  always_ff @(posedge clock_50_mhz_input or negedge reset_n_input) begin
    if (!reset_n_input) begin
      state                     <= IDLE;
      addr                      <= '0;
      watchdog                  <= '0;
      pass_index_output         <= '0;
      error_count_output        <= '0;
      test_running_output       <= 1'b0;
      test_done_output          <= 1'b0;
      test_pass_output          <= 1'b0;
      timeout_error_output      <= 1'b0;
      ctrl.start_output         <= 1'b0;
      ctrl.read_or_write_output <= 1'b0;
      ctrl.address_output       <= '0;
      ctrl.data_output          <= '0;
    end else begin
      ctrl.start_output <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start_test_input) begin
            addr                 <= '0;
            pass_index_output    <= '0;
            error_count_output   <= '0;
            timeout_error_output <= 1'b0;
            test_done_output     <= 1'b0;
            test_pass_output     <= 1'b0;
            test_running_output  <= 1'b1;
            state                <= ISSUE;
          end
        end
        ISSUE: begin
          if (!ctrl.busy_signal_input) begin
            ctrl.start_output         <= 1'b1;
            ctrl.read_or_write_output <= ~pass_index_output[0];
            ctrl.address_output       <= addr;
            ctrl.data_output          <= pass_index_output[0] ? 8'h00 : expected_byte;
            watchdog                  <= '0;
            state                     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (pass_index_output[0] ? ctrl.data_ready_signal_input
                                   : ctrl.writing_finished_signal_input) begin
            if (pass_index_output[0] && mismatch && (error_count_output != '1))
              error_count_output <= error_count_output + ERROR_COUNT_WIDTH'(1);
            state <= WAIT_IDLE;
          end else if (watchdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
            timeout_error_output <= 1'b1;
            test_done_output     <= 1'b1;
            test_running_output  <= 1'b0;
            state                <= DONE;
          end else begin
            watchdog <= watchdog + WD_W'(1);
          end
        end
        WAIT_IDLE: begin
          if (!ctrl.busy_signal_input) state <= NEXT;
        end
        NEXT: begin
          if (addr == LAST_ADDRESS) begin
            addr <= '0;
            if (pass_index_output == 2'd3) begin
              test_done_output    <= 1'b1;
              test_running_output <= 1'b0;
              test_pass_output    <= (error_count_output == '0);
              state               <= DONE;
            end else begin
              pass_index_output <= pass_index_output + 2'd1;
              state             <= ISSUE;
            end
          end else begin
            addr  <= addr + ADDR_WIDTH'(1);
            state <= ISSUE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SRAM_TESTER_ERROR_LOG_EN
  logic logged;

  always_ff @(posedge clock_50_mhz_input or negedge reset_n_input) begin
    if (!reset_n_input) begin
      logged                      <= 1'b0;
      first_error_address_output  <= '0;
      first_error_expected_output <= '0;
      first_error_actual_output   <= '0;
    end else if ((state == IDLE || state == DONE) && start_test_input) begin
      logged                      <= 1'b0;
      first_error_address_output  <= '0;
      first_error_expected_output <= '0;
      first_error_actual_output   <= '0;
    end else if (state == WAIT_ACK && pass_index_output[0] &&
                 ctrl.data_ready_signal_input && mismatch && !logged) begin
      logged                      <= 1'b1;
      first_error_address_output  <= addr;
      first_error_expected_output <= expected_byte;
      first_error_actual_output   <= ctrl.data_from_controller_input;
    end
  end
`else
  assign first_error_address_output  = '0;
  assign first_error_expected_output = '0;
  assign first_error_actual_output   = '0;
`endif

endmodule

// File: tb/tb_sram_march_pattern_tester.sv
// Directed bench: two testers (16-bit and 2-bit error counters) over behavioural SRAM controllers.
module tb_sram_march_pattern_tester;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_test = 1'b0;
  logic start2 = 1'b0;
  always #5 clk = ~clk;

  sram_march_pattern_tester_if #(.ADDR_WIDTH(19)) if1 ();
  sram_march_pattern_tester_if #(.ADDR_WIDTH(19)) if2 ();

  logic        running1, done1, pass1, tmo1;
  logic [1:0]  pidx1;
  logic [15:0] ecnt1;
  logic [18:0] fe_addr1;
  logic [7:0]  fe_exp1, fe_act1;

  logic        running2, done2, pass2, tmo2;
  logic [1:0]  pidx2;
  logic [1:0]  ecnt2;
  logic [18:0] fe_addr2;
  logic [7:0]  fe_exp2, fe_act2;

  sram_march_pattern_tester #(
    .ADDR_WIDTH(19), .LAST_ADDRESS(19'd15), .ERROR_COUNT_WIDTH(16), .TIMEOUT_CYCLES(16)
  ) dut (
    .clock_50_mhz_input(clk), .reset_n_input(rst_n), .start_test_input(start_test),
    .ctrl(if1.master),
    .test_running_output(running1), .test_done_output(done1), .test_pass_output(pass1),
    .timeout_error_output(tmo1), .pass_index_output(pidx1), .error_count_output(ecnt1),
    .first_error_address_output(fe_addr1), .first_error_expected_output(fe_exp1),
    .first_error_actual_output(fe_act1)
  );

  sram_march_pattern_tester #(
    .ADDR_WIDTH(19), .LAST_ADDRESS(19'd15), .ERROR_COUNT_WIDTH(2), .TIMEOUT_CYCLES(16)
  ) dut2 (
    .clock_50_mhz_input(clk), .reset_n_input(rst_n), .start_test_input(start2),
    .ctrl(if2.master),
    .test_running_output(running2), .test_done_output(done2), .test_pass_output(pass2),
    .timeout_error_output(tmo2), .pass_index_output(pidx2), .error_count_output(ecnt2),
    .first_error_address_output(fe_addr2), .first_error_expected_output(fe_exp2),
    .first_error_actual_output(fe_act2)
  );

  // Controller model 1: ideal memory with optional bit0 stuck-at-0 at address 5 and read-ack suppression.
  bit         fault = 1'b0;
  bit         no_ack = 1'b0;
  logic [7:0] mem1 [16];
  logic       m1_busy = 1'b0, m1_dr = 1'b0, m1_wf = 1'b0, m1_rw = 1'b0;
  logic [7:0] m1_q = 8'h00, m1_d = 8'h00;
  logic [3:0] m1_a = 4'h0;
  int         m1_cnt = 0;
  assign if1.busy_signal_input             = m1_busy;
  assign if1.data_ready_signal_input       = m1_dr;
  assign if1.writing_finished_signal_input = m1_wf;
  assign if1.data_from_controller_input    = m1_q;

  always @(posedge clk) begin
    m1_dr <= 1'b0;
    m1_wf <= 1'b0;
    if (m1_cnt == 0) begin
      if (if1.start_output === 1'b1) begin
        m1_busy <= 1'b1;
        m1_cnt  <= 3;
        m1_rw   <= if1.read_or_write_output;
        m1_a    <= if1.address_output[3:0];
        m1_d    <= if1.data_output;
      end
    end else begin
      m1_cnt <= m1_cnt - 1;
      if (m1_cnt == 2) begin
        if (m1_rw) begin
          mem1[m1_a] <= m1_d;
          m1_wf      <= 1'b1;
        end else begin
          m1_q <= (fault && m1_a == 4'd5) ? (mem1[m1_a] & 8'hFE) : mem1[m1_a];
          if (!no_ack) m1_dr <= 1'b1;
        end
      end
      if (m1_cnt == 1) m1_busy <= 1'b0;
    end
  end

  // Controller model 2: returns inverted data on every read.
  logic [7:0] mem2 [16];
  logic       m2_busy = 1'b0, m2_dr = 1'b0, m2_wf = 1'b0, m2_rw = 1'b0;
  logic [7:0] m2_q = 8'h00, m2_d = 8'h00;
  logic [3:0] m2_a = 4'h0;
  int         m2_cnt = 0;
  assign if2.busy_signal_input             = m2_busy;
  assign if2.data_ready_signal_input       = m2_dr;
  assign if2.writing_finished_signal_input = m2_wf;
  assign if2.data_from_controller_input    = m2_q;

  always @(posedge clk) begin
    m2_dr <= 1'b0;
    m2_wf <= 1'b0;
    if (m2_cnt == 0) begin
      if (if2.start_output === 1'b1) begin
        m2_busy <= 1'b1;
        m2_cnt  <= 3;
        m2_rw   <= if2.read_or_write_output;
        m2_a    <= if2.address_output[3:0];
        m2_d    <= if2.data_output;
      end
    end else begin
      m2_cnt <= m2_cnt - 1;
      if (m2_cnt == 2) begin
        if (m2_rw) begin
          mem2[m2_a] <= m2_d;
          m2_wf      <= 1'b1;
        end else begin
          m2_q  <= ~mem2[m2_a];
          m2_dr <= 1'b1;
        end
      end
      if (m2_cnt == 1) m2_busy <= 1'b0;
    end
  end

  int   starts1 = 0;
  int   consec1 = 0;
  logic prev_start1 = 1'b0;
  always @(posedge clk) begin
    if (if1.start_output === 1'b1) starts1 <= starts1 + 1;
    if (if1.start_output === 1'b1 && prev_start1) consec1 <= consec1 + 1;
    prev_start1 <= (if1.start_output === 1'b1);
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start_test = 1'b1;
    @(negedge clk);
    start_test = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done1 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, done1, 1);
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, {if1.start_output, if1.read_or_write_output, if1.address_output, if1.data_output,
                running1, done1, pass1, tmo1, pidx1, ecnt1}, 64'd0);
    check({tag, "_fe"}, {fe_addr1, fe_exp1, fe_act1}, 64'd0);
  endtask

  initial begin
    int base;
    int n;
    bit found;

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Ideal memory: 64 accesses, clean pass.
    base    = starts1;
    pulse_start();
    wait_done("t1_done");
    check("t1_pass", pass1, 1);
    check("t1_errs", ecnt1, 0);
    check("t1_tmo", tmo1, 0);
    check("t1_accesses", starts1 - base, 64);
    check("t1_start_width", consec1, 0);
    check("t1_fe", {fe_addr1, fe_exp1, fe_act1}, 64'd0);

    // Bit0 stuck-at-0 at address 5: only the pass 1 read of 8'h05 fails.
    fault = 1'b1;
    pulse_start();
    wait_done("t2_done");
    check("t2_errs", ecnt1, 1);
    check("t2_pass", pass1, 0);
`ifdef SRAM_TESTER_ERROR_LOG_EN
    check("t2_fe_addr", fe_addr1, 5);
    check("t2_fe_exp", fe_exp1, 8'h05);
    check("t2_fe_act", fe_act1, 8'h04);
`else
    check("t2_fe_tied", {fe_addr1, fe_exp1, fe_act1}, 64'd0);
`endif
    fault = 1'b0;

    // Read acks suppressed: watchdog fires on the first read of pass 1.
    no_ack = 1'b1;
    base   = starts1;
    pulse_start();
    wait_done("t3_done");
    check("t3_tmo", tmo1, 1);
    check("t3_pass", pass1, 0);
    check("t3_pidx", pidx1, 1);
    check("t3_accesses", starts1 - base, 17);
    no_ack = 1'b0;
    repeat (5) @(negedge clk);

    // Asynchronous reset in pass 2 at address 9, then a clean rerun.
    pulse_start();
    found = 1'b0;
    n     = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      n++;
      if (pidx1 == 2'd2 && if1.address_output == 19'd9) found = 1'b1;
    end
    check("t4_reach", found, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("t4_async_rst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pulse_start();
    wait_done("t4_done");
    check("t4_pass", pass1, 1);
    check("t4_tmo", tmo1, 0);

    // start held high: one full run, then an automatic restart with cleared counters.
    fault = 1'b1;
    @(negedge clk);
    start_test = 1'b1;
    @(negedge clk);
    base = starts1;
    wait_done("t5_done");
    check("t5_accesses", starts1 - base, 64);
    check("t5_errs", ecnt1, 1);
    @(negedge clk);
    check("t5_restart_done", done1, 0);
    check("t5_restart_running", running1, 1);
    check("t5_restart_errs", ecnt1, 0);
    start_test = 1'b0;
    wait_done("t5_done2");
    check("t5_errs2", ecnt1, 1);
    fault = 1'b0;

    // 2-bit error counter with every read inverted: saturates at 3.
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n = 0;
    while (done2 !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("t6_done", done2, 1);
    check("t6_errs_sat", ecnt2, 2'b11);
    check("t6_pass", pass2, 0);
    check("t6_tmo", tmo2, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
